// File: rtl/acc_cpu_core_if.sv
// Memory bus of acc_cpu_core: one request at a time, completed by mem_ready.
interface acc_cpu_core_if #(
    parameter int WIDTH = 16
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-5:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Accumulator CPU: 4-bit opcode plus (WIDTH-4)-bit operand, one instruction per
// IDLE->FETCH->EXEC[->MEM] pass, single level-sensitive interrupt with one return slot.
module acc_cpu_core #(
    parameter int WIDTH    = 16,
    parameter int FREE_RUN = 0,
    parameter int IRQ_VEC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  irq,
    acc_cpu_core_if.master        bus,
    output logic [7:0]            data_out,
    output logic                  busy,
    output logic                  halt,
    output logic                  trap
);
    localparam int AW = WIDTH - 4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT, S_TRAP, S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_HALT, OP_TRAP, OP_LDI, OP_LD, OP_ST, OP_ADDI, OP_SUBI,
        OP_ADD, OP_AND, OP_JMP, OP_JZ, OP_JN, OP_OUT, OP_EIDI, OP_IRET
    } op_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [AW-1:0]    epc_q, epc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic             ie_q, ie_d;
    logic             in_isr_q, in_isr_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             step_seen_q, step_seen_d;

    op_e              opcode;
    logic [AW-1:0]    k_addr;
    logic [WIDTH-1:0] k_ext;
    logic [AW-1:0]    pc_inc;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH:0]   alu;
    logic [WIDTH-1:0] and_res;

    assign opcode  = op_e'(inst_q[WIDTH-1 -: 4]);
    assign k_addr  = inst_q[AW-1:0];
    assign k_ext   = {4'b0000, k_addr};
    assign pc_inc  = pc_q + AW'(1);

    // One adder serves ADDI/SUBI (immediate) and ADD (memory); SUBI's bit WIDTH is the borrow.
    assign alu_b   = (opcode == OP_ADD) ? bus.mem_rdata : k_ext;
    assign alu     = (opcode == OP_SUBI) ? ({1'b0, acc_q} - {1'b0, alu_b})
                                         : ({1'b0, acc_q} + {1'b0, alu_b});
    assign and_res = acc_q & bus.mem_rdata;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        acc_d         = acc_q;
        inst_d        = inst_q;
        ie_d          = ie_q;
        in_isr_d      = in_isr_q;
        zero_d        = zero_q;
        neg_d         = neg_q;
        carry_d       = carry_q;
        data_out_d    = data_out_q;
        step_seen_d   = step_seen_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = pc_q;
        bus.mem_wdata = acc_q;

        case (state_q)
            S_IDLE: begin
                if (irq && ie_q) begin
                    epc_d    = pc_q;
                    pc_d     = AW'(IRQ_VEC);
                    ie_d     = 1'b0;
                    in_isr_d = 1'b1;
                end else if (step || (FREE_RUN != 0)) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    inst_d  = bus.mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                pc_d    = pc_inc;
                case (opcode)
                    OP_HALT: state_d = S_HALT;
                    OP_TRAP: begin
                        state_d     = S_TRAP;
                        step_seen_d = 1'b0;
                    end
                    OP_LDI:  acc_d = k_ext;
                    OP_LD, OP_ST, OP_ADD, OP_AND: begin
                        state_d = S_MEM;
                        pc_d    = pc_q;
                    end
                    OP_ADDI, OP_SUBI: begin
                        acc_d   = alu[WIDTH-1:0];
                        carry_d = alu[WIDTH];
                        zero_d  = (alu[WIDTH-1:0] == '0);
                        neg_d   = alu[WIDTH-1];
                    end
                    OP_JMP:  pc_d = k_addr;
                    OP_JZ:   if (zero_q) pc_d = k_addr;
                    OP_JN:   if (neg_q) pc_d = k_addr;
                    OP_OUT:  data_out_d = acc_q[7:0];
                    OP_EIDI: ie_d = k_addr[0];
                    OP_IRET: begin
                        // Returning with interrupts enabled and nothing taken is unrecoverable.
                        if (ie_q && !in_isr_q) begin
                            state_d = S_FAULT;
                            pc_d    = pc_q;
                        end else begin
                            pc_d     = epc_q;
                            ie_d     = 1'b1;
                            in_isr_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = (opcode == OP_ST);
                bus.mem_addr = k_addr;
                if (bus.mem_ready) begin
                    state_d = S_IDLE;
                    pc_d    = pc_inc;
                    case (opcode)
                        OP_LD:  acc_d = bus.mem_rdata;
                        OP_ADD: begin
                            acc_d   = alu[WIDTH-1:0];
                            carry_d = alu[WIDTH];
                            zero_d  = (alu[WIDTH-1:0] == '0);
                            neg_d   = alu[WIDTH-1];
                        end
                        OP_AND: begin
                            acc_d   = and_res;
                            carry_d = 1'b0;
                            zero_d  = (and_res == '0);
                            neg_d   = and_res[WIDTH-1];
                        end
                        default: ;
                    endcase
                end
            end
            S_TRAP: begin
                // Leave only on the falling side of a step pulse seen while trapped.
                if (step) begin
                    step_seen_d = 1'b1;
                end else if (step_seen_q) begin
                    step_seen_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            epc_q       <= '0;
            acc_q       <= '0;
            inst_q      <= '0;
            ie_q        <= 1'b0;
            in_isr_q    <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            data_out_q  <= '0;
            step_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            acc_q       <= acc_d;
            inst_q      <= inst_d;
            ie_q        <= ie_d;
            in_isr_q    <= in_isr_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            data_out_q  <= data_out_d;
            step_seen_q <= step_seen_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
    assign halt     = (state_q == S_HALT) || (state_q == S_FAULT);
    assign trap     = (state_q == S_TRAP) || (state_q == S_FAULT);
endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench: a free-running core and a single-step core, each with its own latency-programmable memory.
module tb_acc_cpu_core;
    localparam logic [3:0] OP_NOP = 4'h0, OP_HALT = 4'h1, OP_TRAP = 4'h2, OP_LDI = 4'h3,
                           OP_LD = 4'h4, OP_ST = 4'h5, OP_ADDI = 4'h6, OP_SUBI = 4'h7,
                           OP_ADD = 4'h8, OP_AND = 4'h9, OP_JMP = 4'hA, OP_JZ = 4'hB,
                           OP_JN = 4'hC, OP_OUT = 4'hD, OP_EIDI = 4'hE, OP_IRET = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_fr, rst_st, step_fr, step, irq_fr, irq_st;
    logic [7:0] fr_dout, st_dout;
    logic fr_busy, fr_halt, fr_trap, st_busy, st_halt, st_trap;

    acc_cpu_core_if #(.WIDTH(16)) bus_fr ();
    acc_cpu_core_if #(.WIDTH(16)) bus_st ();

    acc_cpu_core #(.WIDTH(16), .FREE_RUN(1), .IRQ_VEC(1)) u_fr (
        .clk(clk), .rst(rst_fr), .step(step_fr), .irq(irq_fr), .bus(bus_fr),
        .data_out(fr_dout), .busy(fr_busy), .halt(fr_halt), .trap(fr_trap));

    acc_cpu_core #(.WIDTH(16), .FREE_RUN(0), .IRQ_VEC(1)) u_st (
        .clk(clk), .rst(rst_st), .step(step), .irq(irq_st), .bus(bus_st),
        .data_out(st_dout), .busy(st_busy), .halt(st_halt), .trap(st_trap));

    // Free-run memory: program image plus a written-word overlay, mem_ready after fr_lat wait cycles.
    logic [15:0]   fr_prog [4096];
    logic [15:0]   fr_wmem [4096];
    logic [4095:0] fr_wval;
    logic          fr_clr;
    int            fr_lat, fr_wait, fr_wr_cnt;
    logic [11:0]   fr_waddr;
    logic [15:0]   fr_wdata;

    assign bus_fr.mem_ready = bus_fr.mem_req && (fr_wait >= fr_lat);
    assign bus_fr.mem_rdata = fr_wval[bus_fr.mem_addr] ? fr_wmem[bus_fr.mem_addr] : fr_prog[bus_fr.mem_addr];

    always @(posedge clk) begin
        if (bus_fr.mem_req && !bus_fr.mem_ready) fr_wait <= fr_wait + 1;
        else fr_wait <= 0;
        if (fr_clr) begin
            fr_wval   <= '0;
            fr_wr_cnt <= 0;
        end else if (bus_fr.mem_req && bus_fr.mem_we && bus_fr.mem_ready) begin
            fr_wmem[bus_fr.mem_addr] <= bus_fr.mem_wdata;
            fr_wval[bus_fr.mem_addr] <= 1'b1;
            fr_wr_cnt                <= fr_wr_cnt + 1;
            fr_waddr                 <= bus_fr.mem_addr;
            fr_wdata                 <= bus_fr.mem_wdata;
        end
    end

    // Bus-protocol monitor: request must drop after completion; write cycles must hold addr/data.
    logic fr_prev_rdy;
    int   fr_drop_err, fr_we_cyc, fr_we_bad;
    always @(negedge clk) begin
        if (fr_clr) begin
            fr_prev_rdy <= 1'b0;
            fr_drop_err <= 0;
            fr_we_cyc   <= 0;
            fr_we_bad   <= 0;
        end else begin
            fr_prev_rdy <= bus_fr.mem_req && bus_fr.mem_ready;
            if (fr_prev_rdy && bus_fr.mem_req) fr_drop_err <= fr_drop_err + 1;
            if (bus_fr.mem_req && bus_fr.mem_we) begin
                fr_we_cyc <= fr_we_cyc + 1;
                if (bus_fr.mem_addr != 12'h020 || bus_fr.mem_wdata != 16'h1234) fr_we_bad <= fr_we_bad + 1;
            end
        end
    end

    // Step-mode memory: read-only program image.
    logic [15:0] st_prog [4096];
    int          st_lat, st_wait;
    assign bus_st.mem_ready = bus_st.mem_req && (st_wait >= st_lat);
    assign bus_st.mem_rdata = st_prog[bus_st.mem_addr];
    always @(posedge clk) begin
        if (bus_st.mem_req && !bus_st.mem_ready) st_wait <= st_wait + 1;
        else st_wait <= 0;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] k);
        return {op, k};
    endfunction

    task automatic fr_begin();
        rst_fr = 1'b1;
        fr_clr = 1'b1;
        irq_fr = 1'b0;
        for (int i = 0; i < 4096; i++) fr_prog[i] = '0;
    endtask

    task automatic fr_go(input int lat);
        fr_lat = lat;
        repeat (2) @(negedge clk);
        fr_clr = 1'b0;
        rst_fr = 1'b0;
    endtask

    task automatic fr_wait_halt(input string tag);
        int n = 0;
        while (!fr_halt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, fr_halt, 1'b1);
    endtask

    task automatic step_pulse();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_fr = 1'b1; rst_st = 1'b1; step_fr = 1'b0; step = 1'b0;
        irq_fr = 1'b0; irq_st = 1'b0; fr_clr = 1'b1; fr_lat = 0; st_lat = 1;
        for (int i = 0; i < 4096; i++) begin
            fr_prog[i] = '0;
            st_prog[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_pc", u_st.pc_q, 12'h000);
        check("rst_acc", u_st.acc_q, 16'h0000);
        check("rst_flags", {st_busy, st_halt, st_trap, bus_st.mem_req}, 4'b0000);
        check("rst_dout", st_dout, 8'h00);

        // ADDI carry-out into bit 12 without carry; SUBI borrow through zero.
        fr_begin();
        fr_prog[0] = ins(OP_LDI, 12'h005);
        fr_prog[1] = ins(OP_OUT, 12'h000);
        fr_prog[2] = ins(OP_LDI, 12'hFFF);
        fr_prog[3] = ins(OP_ADDI, 12'h001);
        fr_prog[4] = ins(OP_HALT, 12'h000);
        fr_go(0);
        fr_wait_halt("addi_halt");
        check("addi_acc", u_fr.acc_q, 16'h1000);
        check("addi_czn", {u_fr.carry_q, u_fr.zero_q, u_fr.neg_q}, 3'b000);
        check("addi_dout", fr_dout, 8'h05);

        fr_begin();
        fr_prog[0] = ins(OP_LDI, 12'h000);
        fr_prog[1] = ins(OP_SUBI, 12'h001);
        fr_prog[2] = ins(OP_HALT, 12'h000);
        fr_go(0);
        fr_wait_halt("subi_halt");
        check("subi_acc", u_fr.acc_q, 16'hFFFF);
        check("subi_czn", {u_fr.carry_q, u_fr.zero_q, u_fr.neg_q}, 3'b101);

        // Memory ops and branches, both taken and untaken, with a 2-cycle memory.
        fr_begin();
        fr_prog[0]  = ins(OP_LDI, 12'h0F0);
        fr_prog[1]  = ins(OP_ST, 12'h200);
        fr_prog[2]  = ins(OP_LD, 12'h201);
        fr_prog[3]  = ins(OP_ADD, 12'h200);
        fr_prog[4]  = ins(OP_ST, 12'h204);
        fr_prog[5]  = ins(OP_LD, 12'h202);
        fr_prog[6]  = ins(OP_AND, 12'h201);
        fr_prog[7]  = ins(OP_JZ, 12'h010);
        fr_prog[8]  = ins(OP_JN, 12'h00A);
        fr_prog[9]  = ins(OP_HALT, 12'h000);
        fr_prog[10] = ins(OP_AND, 12'h203);
        fr_prog[11] = ins(OP_JZ, 12'h00D);
        fr_prog[12] = ins(OP_HALT, 12'h000);
        fr_prog[13] = ins(OP_LDI, 12'h0C3);
        fr_prog[14] = ins(OP_OUT, 12'h000);
        fr_prog[15] = ins(OP_HALT, 12'h000);
        fr_prog[16] = ins(OP_HALT, 12'h000);
        fr_prog[12'h201] = 16'hFFFF;
        fr_prog[12'h202] = 16'h8000;
        fr_prog[12'h203] = 16'h0000;
        fr_go(2);
        fr_wait_halt("mem_halt");
        check("mem_wr_cnt", fr_wr_cnt, 2);
        check("mem_st200", fr_wmem[12'h200], 16'h00F0);
        check("mem_add_st204", fr_wmem[12'h204], 16'h00EF);
        check("mem_branch_dout", fr_dout, 8'hC3);
        check("mem_ldi_keeps_zero", {u_fr.carry_q, u_fr.zero_q, u_fr.neg_q}, 3'b010);
        check("mem_req_drop", fr_drop_err, 0);

        // Store held through a 5-cycle memory stall.
        fr_begin();
        fr_prog[0] = ins(OP_LDI, 12'hFFF);
        fr_prog[1] = ins(OP_ADDI, 12'h235);
        fr_prog[2] = ins(OP_ST, 12'h020);
        fr_prog[3] = ins(OP_HALT, 12'h000);
        fr_go(5);
        fr_wait_halt("st_halt");
        check("st_we_cycles", fr_we_cyc, 6);
        check("st_stable", fr_we_bad, 0);
        check("st_wr_cnt", fr_wr_cnt, 1);
        check("st_addr", fr_waddr, 12'h020);
        check("st_data", fr_wdata, 16'h1234);
        check("st_req_drop", fr_drop_err, 0);

        // Interrupt raised during a stalled LD is taken in the following IDLE.
        fr_begin();
        fr_prog[0]  = ins(OP_JMP, 12'h010);
        fr_prog[1]  = ins(OP_LDI, 12'h077);
        fr_prog[2]  = ins(OP_IRET, 12'h000);
        fr_prog[16] = ins(OP_EIDI, 12'h001);
        fr_prog[17] = ins(OP_LD, 12'h300);
        fr_prog[18] = ins(OP_OUT, 12'h000);
        fr_prog[19] = ins(OP_HALT, 12'h000);
        fr_prog[12'h300] = 16'h0055;
        fr_go(3);
        n = 0;
        while (!(bus_fr.mem_req && bus_fr.mem_addr == 12'h300) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("irq_ld_seen", bus_fr.mem_req && bus_fr.mem_addr == 12'h300, 1'b1);
        irq_fr = 1'b1;
        n = 0;
        while (bus_fr.mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("irq_ld_done_pc", u_fr.pc_q, 12'h012);
        check("irq_ld_acc", u_fr.acc_q, 16'h0055);
        check("irq_ie_before", u_fr.ie_q, 1'b1);
        @(negedge clk);
        check("irq_pc_vec", u_fr.pc_q, 12'h001);
        check("irq_epc", u_fr.epc_q, 12'h012);
        check("irq_ie_after", u_fr.ie_q, 1'b0);
        check("irq_no_mem", bus_fr.mem_req, 1'b0);
        irq_fr = 1'b0;
        fr_wait_halt("iret_halt");
        check("iret_dout", fr_dout, 8'h77);
        check("iret_ie", u_fr.ie_q, 1'b1);

        // IRET with interrupts enabled and no entry taken faults; reset clears it.
        fr_begin();
        fr_prog[0] = ins(OP_EIDI, 12'h001);
        fr_prog[1] = ins(OP_IRET, 12'h000);
        fr_go(0);
        fr_wait_halt("fault_halt");
        check("fault_flags", {fr_busy, fr_halt, fr_trap}, 3'b011);
        rst_fr = 1'b1;
        @(negedge clk);
        check("fault_rst", {fr_busy, fr_halt, fr_trap}, 3'b000);

        // Reset while a fetch is stalled abandons it.
        fr_begin();
        fr_prog[0] = ins(OP_LDI, 12'h123);
        fr_prog[1] = ins(OP_EIDI, 12'h001);
        fr_prog[2] = ins(OP_OUT, 12'h000);
        fr_go(2);
        n = 0;
        while (!(bus_fr.mem_req && bus_fr.mem_addr == 12'h003) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("r40_fetch3", bus_fr.mem_req && bus_fr.mem_addr == 12'h003, 1'b1);
        fr_lat = 50;
        repeat (3) @(negedge clk);
        check("r40_pre_dout", fr_dout, 8'h23);
        check("r40_pre_stall", bus_fr.mem_req, 1'b1);
        rst_fr = 1'b1;
        @(negedge clk);
        check("r40_req", {bus_fr.mem_req, bus_fr.mem_we}, 2'b00);
        check("r40_pc_epc", {u_fr.pc_q, u_fr.epc_q}, 24'h000000);
        check("r40_acc_inst", {u_fr.acc_q, u_fr.inst_q}, 32'h00000000);
        check("r40_ie_flags", {u_fr.ie_q, u_fr.zero_q, u_fr.neg_q, u_fr.carry_q}, 4'b0000);
        check("r40_dout", fr_dout, 8'h00);
        check("r40_status", {fr_busy, fr_halt, fr_trap}, 3'b000);
        fr_lat = 0;
        rst_fr = 1'b0;
        @(negedge clk);
        check("r40_first_fetch", {bus_fr.mem_req, bus_fr.mem_we, bus_fr.mem_addr}, {2'b10, 12'h000});

        // Jump to the top of the address space; the following increment wraps.
        fr_begin();
        fr_prog[0]      = ins(OP_JN, 12'h004);
        fr_prog[1]      = ins(OP_LDI, 12'h000);
        fr_prog[2]      = ins(OP_SUBI, 12'h001);
        fr_prog[3]      = ins(OP_JMP, 12'hFFF);
        fr_prog[4]      = ins(OP_HALT, 12'h000);
        fr_prog[12'hFFF] = ins(OP_NOP, 12'h000);
        fr_go(0);
        n = 0;
        while (!(bus_fr.mem_req && bus_fr.mem_addr == 12'hFFF) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wrap_fetch_fff", bus_fr.mem_req && bus_fr.mem_addr == 12'hFFF, 1'b1);
        @(negedge clk);
        n = 0;
        while (!bus_fr.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wrap_next_fetch", bus_fr.mem_addr, 12'h000);
        fr_wait_halt("wrap_halt");
        check("wrap_status", {fr_busy, fr_halt, fr_trap}, 3'b010);

        // Single-step core: one instruction per pulse, TRAP needs step high then low.
        st_prog[0] = ins(OP_LDI, 12'h011);
        st_prog[1] = ins(OP_OUT, 12'h000);
        st_prog[2] = ins(OP_NOP, 12'h000);
        st_prog[3] = ins(OP_TRAP, 12'h000);
        st_prog[4] = ins(OP_LDI, 12'h022);
        st_prog[5] = ins(OP_OUT, 12'h000);
        st_prog[6] = ins(OP_HALT, 12'h000);
        rst_st = 1'b0;
        repeat (6) @(negedge clk);
        check("step_wait_pc", u_st.pc_q, 12'h000);
        check("step_wait_req", bus_st.mem_req, 1'b0);
        step_pulse();
        check("step1_pc", u_st.pc_q, 12'h001);
        check("step1_acc", u_st.acc_q, 16'h0011);
        step_pulse();
        check("step2_dout", st_dout, 8'h11);
        step_pulse();
        check("step3_pc", u_st.pc_q, 12'h003);
        step_pulse();
        check("trap_status", {st_busy, st_halt, st_trap}, 3'b001);
        check("trap_pc", u_st.pc_q, 12'h004);
        step = 1'b1;
        repeat (3) @(negedge clk);
        check("trap_step_high", st_trap, 1'b1);
        step = 1'b0;
        repeat (2) @(negedge clk);
        check("trap_released", {st_trap, st_busy}, 2'b00);
        check("trap_rel_pc", u_st.pc_q, 12'h004);
        step_pulse();
        step_pulse();
        check("resume_dout", st_dout, 8'h22);
        step_pulse();
        check("st_halt_status", {st_busy, st_halt, st_trap}, 3'b010);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step = 1'b1;
            @(negedge clk);
            if (bus_st.mem_req) n++;
            step = 1'b0;
            @(negedge clk);
            if (bus_st.mem_req) n++;
        end
        check("halt_ignores_step", n, 0);
        check("halt_sticky", st_halt, 1'b1);
        rst_st = 1'b1;
        @(negedge clk);
        check("halt_rst", {st_halt, st_busy}, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set data/instruction word width; legal 12..32.
REQ-002 Parameter FREE_RUN, default 0, SHALL select mode: 0 = one instruction per step pulse; 1 = continuous execution.
REQ-003 Parameter IRQ_VEC, default 1, SHALL give the interrupt target address.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 step  input  1  run request; level-sampled in IDLE and TRAP.
REQ-007 irq  input  1  level interrupt request.
REQ-008 mem_req  output  1  memory request valid.
REQ-009 mem_we  output  1  write when high, read when low; meaningful only with mem_req.
REQ-010 mem_addr  output  WIDTH-4  word address.
REQ-011 mem_wdata  output  WIDTH  write data.
REQ-012 mem_ready  input  1  request accepted/completed this cycle.
REQ-013 mem_rdata  input  WIDTH  read data, valid when mem_ready.
REQ-014 data_out  output  8  output port register.
REQ-015 busy, halt, trap  output  1 each  status flags.

Function
REQ-016 Instruction: opcode = inst[WIDTH-1:WIDTH-4]; operand K = inst[WIDTH-5:0], zero-extended to WIDTH.
REQ-017 Opcodes: 0 NOP; 1 HALT; 2 TRAP; 3 LDI acc=K; 4 LD acc=M[K]; 5 ST M[K]=acc; 6 ADDI; 7 SUBI; 8 ADD M[K]; 9 AND M[K]; A JMP pc=K; B JZ; C JN; D OUT data_out=acc[7:0]; E EI/DI (K[0] sets ie); F IRET.
REQ-018 States: IDLE, FETCH, EXEC, MEM, HALT, TRAP, FAULT.
REQ-019 IDLE -> FETCH when step=1 or FREE_RUN=1; otherwise hold.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold all outputs stable until mem_ready; on mem_ready latch inst, go EXEC.
REQ-021 EXEC: single-cycle ops complete; pc <= pc+1 (JMP/taken branch: pc <= K); next state IDLE.
REQ-022 LD/ST/ADD/AND go MEM: mem_req=1, mem_addr=K, mem_we=1 for ST with mem_wdata=acc; complete on mem_ready, pc <= pc+1, then IDLE.
REQ-023 At most one memory request outstanding; mem_req SHALL drop the cycle after mem_ready.
REQ-024 ADD/ADDI/SUBI: WIDTH+1-bit arithmetic; carry = bit WIDTH (SUBI carry = borrow); zero = result==0; neg = result MSB; AND updates zero/neg, clears carry; LDI/LD leave flags unchanged.
REQ-025 JZ taken when zero=1, JN when neg=1; untaken -> pc+1.
REQ-026 pc wraps modulo 2^(WIDTH-4) on increment.
REQ-027 HALT -> HALT state, sticky until reset. TRAP -> TRAP; TRAP -> IDLE when step=0 sampled after step=1 seen in TRAP.
REQ-028 IRET: pc <= epc, ie <= 1. IRET with ie=1 and no pending entry -> FAULT (sticky).
REQ-029 Interrupt: in IDLE with irq=1 and ie=1, before next FETCH: epc <= pc, pc <= IRQ_VEC, ie <= 0; costs one cycle; no memory access.
REQ-030 irq ignored while ie=0; irq asserted mid-instruction waits until IDLE.
REQ-031 busy = state not in {IDLE, HALT, TRAP, FAULT}; halt = HALT or FAULT; trap = TRAP or FAULT.
REQ-032 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-033 rst=1 SHALL force, next edge: state IDLE, pc=0, acc=0, inst=0, epc=0, ie=0, zero=neg=carry=0, data_out=0, mem_req=0, mem_we=0.
REQ-034 rst mid-memory-transaction SHALL abandon it; mem_req low the following cycle regardless of mem_ready.
REQ-035 rst overrides HALT, TRAP and FAULT.

Verification
REQ-036 WIDTH=16, FREE_RUN=1: program LDI 0x005; ADDI 0xFFF? -> use LDI 0xFFF, ADDI 1 -> acc=0x1000, carry=0, zero=0; SUBI 0x1001 path: LDI 0, SUBI 1 -> acc=0xFFFF, neg=1, carry=1.
REQ-037 ST 0x20 with acc=0x1234, mem_ready delayed 5 cycles -> mem_req/mem_addr/mem_wdata stable 6 cycles, single write of 0x1234 at 0x020.
REQ-038 FREE_RUN=0: pc stays 0 until step pulse; each pulse advances exactly one instruction; TRAP at pc=3 -> trap=1, pc=4, resumes only after step high then low.
REQ-039 EI 1, then irq=1 during LD stall -> LD completes, next cycle pc=IRQ_VEC, epc=next pc, ie=0; IRET returns and ie=1.
REQ-040 Assert rst during FETCH stall, release -> all REQ-033 values, first fetch at address 0.
REQ-041 JMP to 0xFFF then NOP -> pc wraps to 0x000; HALT -> halt=1, busy=0, step ignored.
